// File: rtl/alu_pkg.sv
// ALU control codes, ALUOp encodings and R-type Funct values shared by the
// pipelined ID/EX stage and the multicycle control.
package alu_pkg;

    localparam logic [3:0] CTRL_AND     = 4'd0;
    localparam logic [3:0] CTRL_OR      = 4'd1;
    localparam logic [3:0] CTRL_ADD     = 4'd2;
    localparam logic [3:0] CTRL_SUB     = 4'd6;
    localparam logic [3:0] CTRL_SLT     = 4'd7;
    localparam logic [3:0] CTRL_NOR     = 4'd12;
    localparam logic [3:0] CTRL_ILLEGAL = 4'd15;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

endpackage

// File: rtl/alu_control_decode.sv
// Combinational ALUOp/Funct to 4-bit ALU control code; zero latency, no flow control.
// Unknown Funct and the reserved ALUOp both map to the illegal code.
module alu_control_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output logic [3:0] o_alu_control
);

    always_comb begin
        o_alu_control = CTRL_ILLEGAL;
        case (i_alu_op)
            ALUOP_ADD:   o_alu_control = CTRL_ADD;
            ALUOP_SUB:   o_alu_control = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (i_funct)
                    FUNCT_ADD: o_alu_control = CTRL_ADD;
                    FUNCT_SUB: o_alu_control = CTRL_SUB;
                    FUNCT_AND: o_alu_control = CTRL_AND;
                    FUNCT_OR:  o_alu_control = CTRL_OR;
                    FUNCT_SLT: o_alu_control = CTRL_SLT;
                    FUNCT_NOR: o_alu_control = CTRL_NOR;
                    default:   o_alu_control = CTRL_ILLEGAL;
                endcase
            end
            default:     o_alu_control = CTRL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode and EX/MEM, MEM/WB operand forwarding.
// One cycle ID-to-EX latency; stall holds every register, flush (higher priority) inserts a bubble.
module id_ex_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_rs_data,
    input  logic [WIDTH-1:0] i_rt_data,
    input  logic [WIDTH-1:0] i_imm,
    input  logic [4:0]       i_rs,
    input  logic [4:0]       i_rt,
    input  logic [4:0]       i_rd,
    input  logic [1:0]       i_alu_op,
    input  logic [5:0]       i_funct,
    input  logic             i_alu_src,
    input  logic             i_reg_dst,
    input  logic             i_reg_write,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic             i_mem_to_reg,
    input  logic             i_exmem_reg_write,
    input  logic [4:0]       i_exmem_rd,
    input  logic [WIDTH-1:0] i_exmem_result,
    input  logic             i_memwb_reg_write,
    input  logic [4:0]       i_memwb_rd,
    input  logic [WIDTH-1:0] i_memwb_result,
    output logic             o_out_valid,
    output logic [3:0]       o_alu_control,
    output logic [WIDTH-1:0] o_alu_in1,
    output logic [WIDTH-1:0] o_alu_in2,
    output logic [WIDTH-1:0] o_store_data,
    output logic [4:0]       o_dest_reg,
    output logic             o_ex_reg_write,
    output logic             o_ex_mem_read,
    output logic             o_ex_mem_write,
    output logic             o_ex_mem_to_reg,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_illegal_count
);

    logic [3:0]       w_alu_control;
    logic [WIDTH-1:0] w_fwd_rs;
    logic [WIDTH-1:0] w_fwd_rt;

    logic             r_valid;
    logic [3:0]       r_alu_control;
    logic [WIDTH-1:0] r_rs_data;
    logic [WIDTH-1:0] r_rt_data;
    logic [WIDTH-1:0] r_imm;
    logic [4:0]       r_rs;
    logic [4:0]       r_rt;
    logic [4:0]       r_dest;
    logic             r_alu_src;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_mem_to_reg;
    logic [CNT_W-1:0] r_illegal_count;

    alu_control_decode u_decode (
        .i_alu_op      (i_alu_op),
        .i_funct       (i_funct),
        .o_alu_control (w_alu_control)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid       <= 1'b0;
            r_alu_control <= CTRL_ADD;
            r_rs_data     <= '0;
            r_rt_data     <= '0;
            r_imm         <= '0;
            r_rs          <= '0;
            r_rt          <= '0;
            r_dest        <= '0;
            r_alu_src     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
        end else if (i_flush) begin
            // Bubble: only control state matters, data fields keep whatever they held.
            r_valid       <= 1'b0;
            r_alu_control <= CTRL_ADD;
            r_alu_src     <= 1'b0;
            r_reg_write   <= 1'b0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_mem_to_reg  <= 1'b0;
        end else if (!i_stall) begin
            r_valid       <= i_in_valid;
            r_alu_control <= w_alu_control;
            r_rs_data     <= i_rs_data;
            r_rt_data     <= i_rt_data;
            r_imm         <= i_imm;
            r_rs          <= i_rs;
            r_rt          <= i_rt;
            r_dest        <= i_reg_dst ? i_rd : i_rt;
            r_alu_src     <= i_alu_src;
            r_reg_write   <= i_reg_write;
            r_mem_read    <= i_mem_read;
            r_mem_write   <= i_mem_write;
            r_mem_to_reg  <= i_mem_to_reg;
        end
    end

    assign o_illegal = r_valid && (r_alu_control == CTRL_ILLEGAL);

    // Counted as the op leaves, so a stalled illegal op is seen only once.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_illegal_count <= '0;
        end else if (o_illegal && !i_stall && (r_illegal_count != '1)) begin
            r_illegal_count <= r_illegal_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_fwd_rs = r_rs_data;
        if (i_exmem_reg_write && (i_exmem_rd != 5'd0) && (i_exmem_rd == r_rs)) begin
            w_fwd_rs = i_exmem_result;
        end else if (i_memwb_reg_write && (i_memwb_rd != 5'd0) && (i_memwb_rd == r_rs)) begin
            w_fwd_rs = i_memwb_result;
        end
    end

    always_comb begin
        w_fwd_rt = r_rt_data;
        if (i_exmem_reg_write && (i_exmem_rd != 5'd0) && (i_exmem_rd == r_rt)) begin
            w_fwd_rt = i_exmem_result;
        end else if (i_memwb_reg_write && (i_memwb_rd != 5'd0) && (i_memwb_rd == r_rt)) begin
            w_fwd_rt = i_memwb_result;
        end
    end

    assign o_out_valid     = r_valid;
    assign o_alu_control   = r_alu_control;
    assign o_alu_in1       = w_fwd_rs;
    assign o_alu_in2       = r_alu_src ? r_imm : w_fwd_rt;
    assign o_store_data    = w_fwd_rt;
    assign o_dest_reg      = r_dest;
    assign o_ex_reg_write  = r_reg_write;
    assign o_ex_mem_read   = r_mem_read;
    assign o_ex_mem_write  = r_mem_write;
    assign o_ex_mem_to_reg = r_mem_to_reg;
    assign o_illegal_count = r_illegal_count;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, decode, forwarding priority, stall/flush, illegal counting.
module tb_id_ex_stage;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall, flush, in_valid;
    logic [WIDTH-1:0] rs_data, rt_data, imm;
    logic [4:0]       rs, rt, rd;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic             alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    logic             exmem_rw, memwb_rw;
    logic [4:0]       exmem_rd, memwb_rd;
    logic [WIDTH-1:0] exmem_res, memwb_res;
    logic             out_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, illegal;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] alu_in1, alu_in2, store_data;
    logic [4:0]       dest_reg;
    logic [CNT_W-1:0] illegal_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .i_clock           (clk),
        .i_reset_n         (rst_n),
        .i_stall           (stall),
        .i_flush           (flush),
        .i_in_valid        (in_valid),
        .i_rs_data         (rs_data),
        .i_rt_data         (rt_data),
        .i_imm             (imm),
        .i_rs              (rs),
        .i_rt              (rt),
        .i_rd              (rd),
        .i_alu_op          (alu_op),
        .i_funct           (funct),
        .i_alu_src         (alu_src),
        .i_reg_dst         (reg_dst),
        .i_reg_write       (reg_write),
        .i_mem_read        (mem_read),
        .i_mem_write       (mem_write),
        .i_mem_to_reg      (mem_to_reg),
        .i_exmem_reg_write (exmem_rw),
        .i_exmem_rd        (exmem_rd),
        .i_exmem_result    (exmem_res),
        .i_memwb_reg_write (memwb_rw),
        .i_memwb_rd        (memwb_rd),
        .i_memwb_result    (memwb_res),
        .o_out_valid       (out_valid),
        .o_alu_control     (alu_control),
        .o_alu_in1         (alu_in1),
        .o_alu_in2         (alu_in2),
        .o_store_data      (store_data),
        .o_dest_reg        (dest_reg),
        .o_ex_reg_write    (ex_reg_write),
        .o_ex_mem_read     (ex_mem_read),
        .o_ex_mem_write    (ex_mem_write),
        .o_ex_mem_to_reg   (ex_mem_to_reg),
        .o_illegal         (illegal),
        .o_illegal_count   (illegal_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; in_valid = 0;
        rs_data = '0; rt_data = '0; imm = '0;
        rs = '0; rt = '0; rd = '0;
        alu_op = 2'b00; funct = '0;
        alu_src = 0; reg_dst = 0; reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
        exmem_rw = 0; exmem_rd = '0; exmem_res = '0;
        memwb_rw = 0; memwb_rd = '0; memwb_res = '0;
    endtask

    // Decode table: {alu_op, funct, expected control}
    logic [1:0] t_op  [7] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11};
    logic [5:0] t_fn  [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000, 6'b100000};
    logic [3:0] t_exp [7] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd6, 4'd15};

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        // Reset with busy inputs: nothing may leak into the stage.
        in_valid = 1; alu_op = 2'b10; funct = 6'b100111; reg_write = 1; mem_write = 1;
        rs = 5'd5; rs_data = 32'h55; exmem_rw = 1; exmem_rd = 5'd5; exmem_res = 32'hAAAA0000;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ctrl", 32'(alu_control), 32'd2);
        check("rst_count", 32'(illegal_count), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_in1", alu_in1, 32'd0);
        check("rst_in2", alu_in2, 32'd0);
        check("rst_store", store_data, 32'd0);
        check("rst_memwrite", 32'(ex_mem_write), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        exmem_rw = 0;
        tick();
        check("nor_ctrl", 32'(alu_control), 32'd12);
        check("nor_valid", 32'(out_valid), 32'd1);
        check("nor_regwrite", 32'(ex_reg_write), 32'd1);

        // Forwarding priority on Rs.
        clear_inputs();
        in_valid = 1; rs = 5'd5; rs_data = 32'h11;
        exmem_rw = 1; exmem_rd = 5'd5; exmem_res = 32'hAAAA0000;
        memwb_rw = 1; memwb_rd = 5'd5; memwb_res = 32'h1234;
        tick();
        check("fwd_exmem_wins", alu_in1, 32'hAAAA0000);
        check("fwd_add_ctrl", 32'(alu_control), 32'd2);
        exmem_rd = 5'd6; #1;
        check("fwd_memwb", alu_in1, 32'h1234);
        memwb_rw = 0; #1;
        check("fwd_none", alu_in1, 32'h11);

        // Register 0 is never forwarded.
        rs = 5'd0; rs_data = 32'd0; exmem_rw = 1; exmem_rd = 5'd0; exmem_res = 32'd7;
        tick();
        check("fwd_r0", alu_in1, 32'd0);

        // Rt forwarding feeds store data; ALUSrc selects the immediate.
        clear_inputs();
        in_valid = 1; rt = 5'd3; rt_data = 32'h33; imm = 32'h99; alu_src = 1;
        memwb_rw = 1; memwb_rd = 5'd3; memwb_res = 32'h77;
        tick();
        check("imm_in2", alu_in2, 32'h99);
        check("fwd_store", store_data, 32'h77);

        // Load ADD, then stall three cycles with changing inputs.
        clear_inputs();
        in_valid = 1; alu_op = 2'b00; rs = 5'd7; rs_data = 32'h70; rt = 5'd9; rt_data = 32'h50;
        rd = 5'd4; reg_dst = 1; reg_write = 1;
        tick();
        check("add_in2", alu_in2, 32'h50);
        check("add_dest", 32'(dest_reg), 32'd4);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 0; alu_op = 2'b01; rs_data = 32'hF0 + 32'(i); rt_data = 32'hDEAD; rd = 5'd8;
            reg_write = 0; mem_write = 1;
            tick();
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_ctrl", 32'(alu_control), 32'd2);
            check("stall_in1", alu_in1, 32'h70);
            check("stall_dest", 32'(dest_reg), 32'd4);
        end
        memwb_rw = 1; memwb_rd = 5'd9; memwb_res = 32'hBEEF; #1;
        check("stall_fwd_in2", alu_in2, 32'hBEEF);
        memwb_res = 32'hCAFE; #1;
        check("stall_fwd_follow", alu_in2, 32'hCAFE);

        // Flush beats stall.
        flush = 1; mem_write = 1; in_valid = 1; alu_op = 2'b10; funct = 6'b000000;
        tick();
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_memwrite", 32'(ex_mem_write), 32'd0);
        check("flush_ctrl", 32'(alu_control), 32'd2);
        check("flush_regwrite", 32'(ex_reg_write), 32'd0);

        // Decode table, with bubbles so nothing is counted.
        clear_inputs();
        for (int i = 0; i < 7; i++) begin
            alu_op = t_op[i]; funct = t_fn[i];
            tick();
            check($sformatf("decode_%0d", i), 32'(alu_control), 32'(t_exp[i]));
        end
        check("bubble_count", 32'(illegal_count), 32'd0);

        // Illegal op counts when it leaves the stage.
        in_valid = 1; alu_op = 2'b10; funct = 6'b000000;
        tick();
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_ctrl", 32'(alu_control), 32'd15);
        check("ill_count_before", 32'(illegal_count), 32'd0);
        in_valid = 0;
        tick();
        check("ill_count_one", 32'(illegal_count), 32'd1);
        check("ill_flag_clear", 32'(illegal), 32'd0);

        // Stalled illegal op counts once.
        in_valid = 1;
        tick();
        stall = 1; in_valid = 0;
        tick(); tick(); tick();
        check("ill_stall_hold", 32'(illegal_count), 32'd1);
        stall = 0;
        tick();
        check("ill_stall_once", 32'(illegal_count), 32'd2);

        // Saturation.
        in_valid = 1;
        for (int i = 0; i < 300; i++) tick();
        check("ill_saturate", 32'(illegal_count), 32'd255);
        tick(); tick();
        check("ill_no_wrap", 32'(illegal_count), 32'd255);

        // Reset during stall acts without a clock edge.
        stall = 1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_count", 32'(illegal_count), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_ctrl", 32'(alu_control), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly upstream of the 32-bit ALU. It registers decoded instruction fields and control bits, and decodes ALUOp/Funct into the ALU's 4-bit Control code. It applies EX/MEM and MEM/WB forwarding to produce Input1/Input2, and supports hazard-unit stall and branch flush. It also counts illegal ALU operations for debug.

## Interface
Parameters:
- WIDTH, 32, datapath width.
- CNT_W, 8, width of the illegal-operation counter.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hold all stage registers.
- Flush  in  1  insert a bubble.
- In_Valid  in  1  ID holds a real instruction.
- Rs_Data, Rt_Data  in  WIDTH  register-file read data.
- Imm  in  WIDTH  sign-extended immediate.
- Rs, Rt, Rd  in  5  register numbers.
- ALUOp  in  2  00 add, 01 sub, 10 R-type by Funct, 11 reserved.
- Funct  in  6  R-type function field.
- ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemToReg  in  1 each  main-control bits.
- ExMem_RegWrite  in  1  EX/MEM write enable, forwarding source.
- ExMem_Rd  in  5  EX/MEM destination register.
- ExMem_Result  in  WIDTH  EX/MEM result.
- MemWb_RegWrite  in  1  MEM/WB write enable, forwarding source.
- MemWb_Rd  in  5  MEM/WB destination register.
- MemWb_Result  in  WIDTH  MEM/WB result.
- Out_Valid  out  1  EX holds a real instruction.
- ALU_Control  out  4  drives ALU Control.
- ALU_In1, ALU_In2  out  WIDTH  drive ALU Input1/Input2.
- Store_Data  out  WIDTH  forwarded Rt value for stores.
- Dest_Reg  out  5  Rd if RegDst, else Rt.
- Ex_RegWrite, Ex_MemRead, Ex_MemWrite, Ex_MemToReg  out  1 each  registered control bits.
- Illegal  out  1  registered ALU_Control is 4'b1111 and Out_Valid is 1.
- Illegal_Count  out  CNT_W  saturating count of illegal ops.

## Operation
- Decode happens before the register:
  - ALUOp 00 → 2 (ADD).
  - ALUOp 01 → 6 (SUB).
  - ALUOp 11 → 4'b1111.
  - ALUOp 10 decodes Funct: 100000→2, 100010→6, 100100→0, 100101→1, 101010→7, 100111→12.
  - Any other Funct → 4'b1111, the illegal code.
- Register update on each rising Clock edge, by priority:
  - Flush=1: Out_Valid, Ex_RegWrite, Ex_MemRead and Ex_MemWrite clear to 0. ALU_Control becomes 2. Data fields may take any value.
  - Else Stall=1: all registers hold.
  - Else: all registers load the inputs; Out_Valid loads In_Valid.
- Flush has priority over Stall when both are asserted.
- Forwarding is combinational from the registered fields, evaluated separately for registered Rs and registered Rt:
  - EX/MEM is used if ExMem_RegWrite=1, ExMem_Rd≠0 and ExMem_Rd matches the field.
  - Otherwise MEM/WB is used if MemWb_RegWrite=1, MemWb_Rd≠0 and MemWb_Rd matches the field.
  - Otherwise the registered read data is used.
  - EX/MEM wins when both sources match.
- Forwarding stays live during Stall, so held operands pick up newly produced results.
- Output selection:
  - ALU_In1 = forwarded Rs value.
  - Store_Data = forwarded Rt value.
  - ALU_In2 = registered Imm if registered ALUSrc=1, else forwarded Rt value.
- Illegal_Count increments by 1 on each edge where Illegal=1 and Stall=0. It saturates at all-ones and does not wrap.

## Timing
- Latency from ID inputs to registered outputs is 1 cycle. Forwarding muxes add no cycles.
- Asynchronous reset (Reset=0) sets:
  - all registered bits to 0,
  - ALU_Control to 2,
  - Out_Valid, Illegal and Illegal_Count to 0.
- With no forwarding match, ALU_In1, ALU_In2 and Store_Data read 0 after reset.
- Reset asserted mid-stall or mid-flush takes effect immediately. Release of reset is synchronised externally.
- A stalled illegal op counts once, on the edge where it leaves the stage.

## Structure
- Shared package `alu_pkg`:
  - ALU control codes: AND=0, OR=1, ADD=2, SUB=6, SLT=7, NOR=12, ILLEGAL=15.
  - ALUOp encodings.
  - Funct constants.
- Sub-module `alu_control_decode`: combinational ALUOp/Funct → 4-bit code. It is reusable by the multicycle control.
- Forwarding logic lives inside id_ex_stage.

## Test plan
- Reset with inputs active → Out_Valid=0, ALU_Control=2, Illegal_Count=0. After release, ALUOp=10 with Funct=100111 → ALU_Control=12 next cycle.
- Rs=5 with ExMem_Rd=5 (RegWrite=1, result 0xAAAA0000) and MemWb_Rd=5 (result 0x1234) → ALU_In1=0xAAAA0000. Drop the EX/MEM match → ALU_In1=0x1234.
- Rs=0 with ExMem_Rd=0, ExMem_RegWrite=1, ExMem_Result=7, Rs_Data=0 → ALU_In1=0.
- Load ADD; assert Stall for 3 cycles while changing inputs → outputs hold. Change MemWb_Result for the matching Rt → ALU_In2 follows it during the stall.
- Stall and Flush asserted together → Out_Valid=0, Ex_MemWrite=0, ALU_Control=2.
- ALUOp=10 with Funct=000000 → Illegal=1, ALU_Control=15, Illegal_Count=1. Forcing 300 illegal ops → Illegal_Count=255.
